// File: rtl/galois_addsub_serial.sv
// Limb-serial modular add/subtract over GF(MODULUS), W bits of each operand per cycle, LSB limb first.
// Latency L+1 cycles from the en sample to the done pulse (L = ceil(N_BITS/W)); one op per L+2 cycles.
// No backpressure: en is sampled only in IDLE, and an en seen while busy is dropped, not queued.
// Ports: clk, rst (sync, active-high), en/op/num1/num2 (start + captured operands),
//        result (registered, held between ops), busy (CALC or FINAL), done (one-cycle pulse in FINAL).
module galois_addsub_serial #(
  parameter int N_BITS = 254,
  parameter int W      = 64,
  parameter logic [N_BITS-1:0] MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              op,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic [N_BITS-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int L  = (N_BITS + W - 1) / W;
  localparam int PW = L * W;                 // padded width, a whole number of limbs
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [PW-1:0] P_PAD = PW'(MODULUS);

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   a_q, b_q, p_q, s_q, t_q;
  logic            op_q, c1, c2;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    a_l, b_l, p_l;
  logic [W:0]      s_w, t_w;
  logic            c1_n, c2_n, last, sel;
  logic [PW-1:0]   s_nx, t_nx;

  // Per-limb datapath: chain 1 forms a+b (or a-b), chain 2 forms that minus p (or plus p).
  // Bit W of each (W+1)-bit limb result is the carry/borrow fed into the next limb.
  always_comb begin
    a_l = a_q[W-1:0];
    b_l = b_q[W-1:0];
    p_l = p_q[W-1:0];
    if (!op_q) begin
      s_w = {1'b0, a_l} + {1'b0, b_l} + {{W{1'b0}}, c1};
      t_w = {1'b0, s_w[W-1:0]} - {1'b0, p_l} - {{W{1'b0}}, c2};
    end else begin
      s_w = {1'b0, a_l} - {1'b0, b_l} - {{W{1'b0}}, c1};
      t_w = {1'b0, s_w[W-1:0]} + {1'b0, p_l} + {{W{1'b0}}, c2};
    end
    c1_n = s_w[W];
    c2_n = t_w[W];
    // New limb enters at the top; after L shifts limb 0 sits at bit 0.
    s_nx = {s_w[W-1:0], s_q[PW-1:W]};
    t_nx = {t_w[W-1:0], t_q[PW-1:W]};
    last = (cnt == CW'(L - 1));
    // Add: sum >= p when the sum carried out or sum-p did not borrow.
    // Sub: a negative difference (final borrow) needs p added back.
    sel  = op_q ? c1_n : (c1_n | ~c2_n);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en)   state_n = CALC;
      CALC:    if (last) state_n = FINAL;
      FINAL:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      s_q    <= '0;
      t_q    <= '0;
      op_q   <= 1'b0;
      c1     <= 1'b0;
      c2     <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_q  <= PW'(num1);
            b_q  <= PW'(num2);
            p_q  <= P_PAD;
            op_q <= op;
            c1   <= 1'b0;
            c2   <= 1'b0;
            cnt  <= '0;
          end
        end
        CALC: begin
          a_q <= a_q >> W;
          b_q <= b_q >> W;
          p_q <= p_q >> W;
          s_q <= s_nx;
          t_q <= t_nx;
          c1  <= c1_n;
          c2  <= c2_n;
          cnt <= cnt + 1'b1;
          // Result is written on the edge into FINAL so it is valid alongside done.
          if (last) result <= sel ? t_nx[N_BITS-1:0] : s_nx[N_BITS-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
